mc_ctrl_unit: RTL and testbench

- Multi-cycle control unit that sequences the program counter, instruction register, register file, ALU and data memory of the multi-cycle CPU.
- A Moore/Mealy FSM walks each instruction through IF/ID/EXE/MEM/WB.
- It asserts PCWre for exactly one cycle, the last cycle of each instruction, so the PC register advances once per retired instruction.
- Sits between the instruction register (opcode source) and the datapath muxes and enables.

---
 rtl/mc_ctrl_pkg.sv | 65 ++++++
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_decode.sv | 66 ++++++
 rtl/mc_ctrl_unit.sv | 177 +++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [1:0] PCSRC_NEXT = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_RS   = 2'b10;
   localparam logic [1:0] PCSRC_JMP  = 2'b11;

   localparam logic [1:0] RDST_R31 = 2'b00;
   localparam logic [1:0] RDST_RT  = 2'b01;
   localparam logic [1:0] RDST_RD  = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;

   typedef struct packed {
      logic       pc_wre;
      logic       ir_wre;
      logic       ins_mem_rw;
      logic       ext_sel;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic       m_rd;
      logic       m_wr;
      logic       db_data_src;
      logic       reg_wre;
      logic [1:0] reg_dst;
      logic       wr_reg_d_src;
      logic [1:0] pc_src;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the control unit (master) and the datapath (slave):
// opcode/flags in, mux selects and enables out.
interface mc_ctrl_if #(parameter int OPW = 6);

   logic [OPW-1:0] opcode;
   logic           zero;
   logic           sign;
   logic           PCWre;
   logic           IRWre;
   logic           InsMemRW;
   logic           ExtSel;
   logic           ALUSrcA;
   logic           ALUSrcB;
   logic [2:0]     ALUOp;
   logic           mRD;
   logic           mWR;
   logic           DBDataSrc;
   logic           RegWre;
   logic [1:0]     RegDst;
   logic           WrRegDSrc;
   logic [1:0]     PCSrc;

   modport master (
      input  opcode, zero, sign,
      output PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
             mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc
   );

   modport slave (
      output opcode, zero, sign,
      input  PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
             mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc
   );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decoder: instruction group flags, ALU control and
// branch resolution from the ALU zero/sign flags.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           sign,
   output logic           is_rtype,
   output logic           is_itype,
   output logic           is_branch,
   output logic           is_jump,
   output logic           is_mem,
   output logic           is_halt,
   output logic           is_legal,
   output logic           is_load,
   output logic           is_jr,
   output logic           is_jal,
   output logic           br_taken,
   output logic           alu_src_a,
   output logic           alu_src_b,
   output logic           ext_sel,
   output logic [2:0]     alu_op
);

   always_comb begin
      is_rtype  = 1'b0;
      is_itype  = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_mem    = 1'b0;
      is_halt   = 1'b0;
      is_load   = 1'b0;
      is_jr     = 1'b0;
      is_jal    = 1'b0;
      br_taken  = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      ext_sel   = 1'b0;
      alu_op    = ALU_ADD;
      case (opcode)
         OPW'(OP_ADD):   is_rtype = 1'b1;
         OPW'(OP_SUB):   begin is_rtype = 1'b1; alu_op = ALU_SUB; end
         OPW'(OP_AND):   begin is_rtype = 1'b1; alu_op = ALU_AND; end
         OPW'(OP_SLT):   begin is_rtype = 1'b1; alu_op = ALU_SLT; end
         OPW'(OP_SLL):   begin is_rtype = 1'b1; alu_op = ALU_SLL; alu_src_a = 1'b1; end
         OPW'(OP_ADDIU): begin is_itype = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; end
         OPW'(OP_ANDI):  begin is_itype = 1'b1; alu_src_b = 1'b1; alu_op = ALU_AND; end
         OPW'(OP_ORI):   begin is_itype = 1'b1; alu_src_b = 1'b1; alu_op = ALU_OR; end
         OPW'(OP_SW):    begin is_mem = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; end
         OPW'(OP_LW):    begin is_mem = 1'b1; is_load = 1'b1; alu_src_b = 1'b1; ext_sel = 1'b1; end
         OPW'(OP_BEQ):   begin is_branch = 1'b1; alu_op = ALU_SUB; ext_sel = 1'b1; br_taken = zero; end
         OPW'(OP_BNE):   begin is_branch = 1'b1; alu_op = ALU_SUB; ext_sel = 1'b1; br_taken = ~zero; end
         OPW'(OP_BLTZ):  begin is_branch = 1'b1; alu_op = ALU_SUB; ext_sel = 1'b1; br_taken = sign; end
         OPW'(OP_J):     is_jump = 1'b1;
         OPW'(OP_JR):    begin is_jump = 1'b1; is_jr = 1'b1; end
         OPW'(OP_JAL):   begin is_jump = 1'b1; is_jal = 1'b1; end
         OPW'(OP_HALT):  is_halt = 1'b1;
         default: ;
      endcase
      is_legal = is_rtype | is_itype | is_branch | is_jump | is_mem | is_halt;
   end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB). Optional retire counter
// is built when CTRL_RETIRE_CNT_EN is defined.
//
// state  | meaning
// S_IF   | fetch: load IR from instruction memory
// S_ID   | decode; jumps, halt and undefined opcodes resolve here
// S_EXE  | ALU operation; branches resolve here
// S_MEM  | data memory access (lw read, sw write + retire)
// S_WB   | register write-back + retire
// S_HALT | stopped until reset
module mc_ctrl_unit
   import mc_ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int RCNT_W = 32
) (
   input  logic              clk,
   input  logic              Reset,
   mc_ctrl_if.master         bus
`ifdef CTRL_RETIRE_CNT_EN
   ,
   output logic [RCNT_W-1:0] retire_cnt
`endif
);

   if (RCNT_W < 1) begin : g_bad_rcnt_w
      $error("RCNT_W must be at least 1");
   end

   state_t     state_q;
   state_t     state_d;
   ctrl_t      ctl;

   logic       is_rtype;
   logic       is_itype;
   logic       is_branch;
   logic       is_jump;
   logic       is_mem;
   logic       is_halt;
   logic       is_legal;
   logic       is_load;
   logic       is_jr;
   logic       is_jal;
   logic       br_taken;
   logic       alu_src_a;
   logic       alu_src_b;
   logic       ext_sel;
   logic [2:0] alu_op;

   mc_ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode    (bus.opcode),
      .zero      (bus.zero),
      .sign      (bus.sign),
      .is_rtype  (is_rtype),
      .is_itype  (is_itype),
      .is_branch (is_branch),
      .is_jump   (is_jump),
      .is_mem    (is_mem),
      .is_halt   (is_halt),
      .is_legal  (is_legal),
      .is_load   (is_load),
      .is_jr     (is_jr),
      .is_jal    (is_jal),
      .br_taken  (br_taken),
      .alu_src_a (alu_src_a),
      .alu_src_b (alu_src_b),
      .ext_sel   (ext_sel),
      .alu_op    (alu_op)
   );

   always_ff @(posedge clk) begin
      if (!Reset) state_q <= S_IF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ctl     = '0;

      // ALU control stays stable through MEM/WB so the result and DB remain valid
      if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
         ctl.ext_sel   = ext_sel;
         ctl.alu_src_a = alu_src_a;
         ctl.alu_src_b = alu_src_b;
         ctl.alu_op    = alu_op;
      end

      case (state_q)
         S_IF: begin
            ctl.ir_wre     = 1'b1;
            ctl.ins_mem_rw = 1'b1;
            state_d        = S_ID;
         end
         S_ID: begin
            if (is_jump) begin
               ctl.pc_wre = 1'b1;
               ctl.pc_src = is_jr ? PCSRC_RS : PCSRC_JMP;
               if (is_jal) begin
                  ctl.reg_wre      = 1'b1;
                  ctl.reg_dst      = RDST_R31;
                  ctl.wr_reg_d_src = 1'b0;
               end
               state_d = S_IF;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else if (!is_legal) begin
               ctl.pc_wre = 1'b1;
               ctl.pc_src = PCSRC_NEXT;
               state_d    = S_IF;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            if (is_branch) begin
               ctl.pc_wre = 1'b1;
               ctl.pc_src = br_taken ? PCSRC_BR : PCSRC_NEXT;
               state_d    = S_IF;
            end else if (is_mem) begin
               state_d = S_MEM;
            end else if (is_rtype || is_itype) begin
               state_d = S_WB;
            end else begin
               state_d = S_IF;
            end
         end
         S_MEM: begin
            if (is_load) begin
               ctl.m_rd = 1'b1;
               state_d  = S_WB;
            end else begin
               ctl.m_wr   = 1'b1;
               ctl.pc_wre = 1'b1;
               ctl.pc_src = PCSRC_NEXT;
               state_d    = S_IF;
            end
         end
         S_WB: begin
            ctl.reg_wre      = 1'b1;
            ctl.wr_reg_d_src = 1'b1;
            ctl.pc_wre       = 1'b1;
            ctl.pc_src       = PCSRC_NEXT;
            ctl.db_data_src  = is_load;
            ctl.reg_dst      = is_rtype ? RDST_RD : RDST_RT;
            state_d          = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase

      // reset aborts the current cycle: no PC, IR, register or memory writes
      if (!Reset) ctl = '0;
   end

   assign bus.PCWre     = ctl.pc_wre;
   assign bus.IRWre     = ctl.ir_wre;
   assign bus.InsMemRW  = ctl.ins_mem_rw;
   assign bus.ExtSel    = ctl.ext_sel;
   assign bus.ALUSrcA   = ctl.alu_src_a;
   assign bus.ALUSrcB   = ctl.alu_src_b;
   assign bus.ALUOp     = ctl.alu_op;
   assign bus.mRD       = ctl.m_rd;
   assign bus.mWR       = ctl.m_wr;
   assign bus.DBDataSrc = ctl.db_data_src;
   assign bus.RegWre    = ctl.reg_wre;
   assign bus.RegDst    = ctl.reg_dst;
   assign bus.WrRegDSrc = ctl.wr_reg_d_src;
   assign bus.PCSrc     = ctl.pc_src;

`ifdef CTRL_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (!Reset)          retire_cnt <= '0;
      else if (ctl.pc_wre) retire_cnt <= retire_cnt + RCNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: a per-instruction reference model queues
// the expected control word for every cycle; a negedge monitor compares.
module tb_mc_ctrl_unit;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   mc_ctrl_if #(.OPW(6)) bus ();

`ifdef CTRL_RETIRE_CNT_EN
   logic [31:0] retire_cnt;
`endif

   mc_ctrl_unit #(.OPW(6), .RCNT_W(32)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .bus        (bus)
`ifdef CTRL_RETIRE_CNT_EN
      ,
      .retire_cnt (retire_cnt)
`endif
   );

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
   localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
   localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110;
   localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
   localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
   localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

   logic [5:0] ops [16] = '{ADD, SUB, ADDIU, AND_, ANDI, ORI, SLL, SLT,
                            SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

   typedef struct packed {
      logic       PCWre;
      logic       IRWre;
      logic       InsMemRW;
      logic       ExtSel;
      logic       ALUSrcA;
      logic       ALUSrcB;
      logic [2:0] ALUOp;
      logic       mRD;
      logic       mWR;
      logic       DBDataSrc;
      logic       RegWre;
      logic [1:0] RegDst;
      logic       WrRegDSrc;
      logic [1:0] PCSrc;
   } cv_t;

   typedef struct packed {
      cv_t         cv;
      logic        rc_chk;
      logic [31:0] rc;
   } sb_t;

   typedef enum {C_ARITH_R, C_ARITH_I, C_LW, C_SW, C_BR, C_JMP, C_HALT, C_NOP} cls_t;

   sb_t         sb[$];
   cv_t         exp_seq[$];
   logic [31:0] rc_model = '0;
   int          checks = 0;
   int          errors = 0;
   logic        done = 1'b0;
   logic        final_checked = 1'b0;

   function automatic cls_t classify(input logic [5:0] op);
      case (op)
         ADD, SUB, AND_, SLL, SLT: return C_ARITH_R;
         ADDIU, ANDI, ORI:         return C_ARITH_I;
         LW:                       return C_LW;
         SW:                       return C_SW;
         BEQ, BNE, BLTZ:           return C_BR;
         J, JR, JAL:               return C_JMP;
         HALT:                     return C_HALT;
         default:                  return C_NOP;
      endcase
   endfunction

   // ALU-side fields: extension, operand selects, operation
   function automatic cv_t alu_fields(input logic [5:0] op);
      cv_t c = '0;
      case (op)
         SUB:             c.ALUOp = 3'd1;
         ADDIU:           begin c.ALUSrcB = 1; c.ExtSel = 1; end
         AND_:            c.ALUOp = 3'd2;
         ANDI:            begin c.ALUOp = 3'd2; c.ALUSrcB = 1; end
         ORI:             begin c.ALUOp = 3'd3; c.ALUSrcB = 1; end
         SLL:             begin c.ALUOp = 3'd5; c.ALUSrcA = 1; end
         SLT:             c.ALUOp = 3'd4;
         SW, LW:          begin c.ALUSrcB = 1; c.ExtSel = 1; end
         BEQ, BNE, BLTZ:  begin c.ALUOp = 3'd1; c.ExtSel = 1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic branch_taken(input logic [5:0] op, input logic z, input logic s);
      return (op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s);
   endfunction

   // Expected control word for each cycle of one instruction, starting at fetch
   task automatic build(input logic [5:0] op, input logic z, input logic s);
      cv_t  c;
      cv_t  a;
      cls_t k;
      k = classify(op);
      a = alu_fields(op);
      exp_seq.delete();
      c = '0; c.IRWre = 1; c.InsMemRW = 1;
      exp_seq.push_back(c);
      c = '0;
      if (k == C_JMP) begin
         c.PCWre = 1;
         c.PCSrc = (op == JR) ? 2'b10 : 2'b11;
         if (op == JAL) c.RegWre = 1;
         exp_seq.push_back(c);
      end else if (k == C_NOP) begin
         c.PCWre = 1;
         exp_seq.push_back(c);
      end else if (k == C_HALT) begin
         exp_seq.push_back(c);
      end else begin
         exp_seq.push_back(c);
         c = a;
         if (k == C_BR) begin
            c.PCWre = 1;
            c.PCSrc = branch_taken(op, z, s) ? 2'b01 : 2'b00;
         end
         exp_seq.push_back(c);
         if (k == C_SW) begin
            c = a; c.mWR = 1; c.PCWre = 1;
            exp_seq.push_back(c);
         end else if (k == C_LW) begin
            c = a; c.mRD = 1;
            exp_seq.push_back(c);
         end
         if (k == C_LW || k == C_ARITH_R || k == C_ARITH_I) begin
            c = a;
            c.RegWre = 1; c.WrRegDSrc = 1; c.PCWre = 1;
            c.DBDataSrc = (k == C_LW);
            c.RegDst = (k == C_ARITH_R) ? 2'b10 : 2'b01;
            exp_seq.push_back(c);
         end
      end
   endtask

   task automatic push_cv(input cv_t c);
      sb_t e;
      e.cv = c;
      e.rc_chk = 1'b1;
      e.rc = rc_model;
      sb.push_back(e);
      if (c.PCWre) rc_model = rc_model + 32'd1;
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
      bus.opcode = op;
      bus.zero = z;
      bus.sign = s;
      build(op, z, s);
      foreach (exp_seq[i]) push_cv(exp_seq[i]);
      repeat (exp_seq.size()) @(posedge clk);
      #1;
   endtask

   task automatic reset_cycle();
      Reset = 1'b0;
      push_cv('0);
      rc_model = '0;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      sb_t e;
      cv_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ExtSel, bus.ALUSrcA, bus.ALUSrcB,
              bus.ALUOp, bus.mRD, bus.mWR, bus.DBDataSrc, bus.RegWre, bus.RegDst,
              bus.WrRegDSrc, bus.PCSrc};
         checks++;
         if (a !== e.cv) begin
            errors++;
            $display("FAIL ctrl_word t=%0t op=%b got=%h expected=%h", $time, bus.opcode, a, e.cv);
         end
`ifdef CTRL_RETIRE_CNT_EN
         if (e.rc_chk) begin
            checks++;
            if (retire_cnt !== e.rc) begin
               errors++;
               $display("FAIL retire_cnt t=%0t got=%0d expected=%0d", $time, retire_cnt, e.rc);
            end
         end
`endif
      end else if (done && !final_checked) begin
         final_checked = 1'b1;
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
         end
      end
   end

   initial begin
      logic [5:0] op;
      Reset = 1'b0;
      bus.opcode = ADD;
      bus.zero = 1'b0;
      bus.sign = 1'b0;
      @(posedge clk);
      #1;
      reset_cycle();
      reset_cycle();
      Reset = 1'b1;

      run_instr(ADD, 1'b0, 1'b0);
      run_instr(LW, 1'b1, 1'b0);
      run_instr(BEQ, 1'b1, 1'b0);
      run_instr(BEQ, 1'b0, 1'b1);
      run_instr(JAL, 1'b0, 1'b0);

      reset_cycle();
      Reset = 1'b1;
      run_instr(ADD, 1'b0, 1'b0);
      run_instr(SW, 1'b0, 1'b0);
      run_instr(J, 1'b0, 1'b0);

      // reset during the MEM cycle of a store
      bus.opcode = SW;
      build(SW, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push_cv(exp_seq[i]);
      repeat (3) @(posedge clk);
      #1;
      reset_cycle();
      Reset = 1'b1;

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 62));
         else                           op = ops[$urandom_range(0, 15)];
         run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      run_instr(HALT, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         bus.opcode = 6'($urandom_range(0, 63));
         bus.zero = 1'($urandom_range(0, 1));
         push_cv('0);
         @(posedge clk);
         #1;
      end
      reset_cycle();
      Reset = 1'b1;
      run_instr(ADD, 1'b1, 1'b1);
      run_instr(BNE, 1'b0, 1'b0);
      run_instr(BLTZ, 1'b0, 1'b1);

      done = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
